// File: rtl/alu_bit_sequencer.sv
// alu_bit_sequencer: drives an external 1-bit ALU slice over WIDTH cycles and
// reassembles the bit-serial result with its final carry and illegal-opcode flag.
module alu_bit_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       op_sel,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic [2:0]       alu_sel,
    output logic             alu_a,
    output logic             alu_b,
    output logic             alu_cin,
    input  logic             alu_out,
    input  logic             alu_cout,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] result,
    output logic             res_cout,
    output logic             res_err,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH + 1);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d, cout_q, cout_d, err_q, err_d;
    logic             run, arith, illegal_in;

    assign run        = state_q == RUN;
    assign arith      = op_q == 3'b101 || op_q == 3'b110;
    assign illegal_in = op_sel == 3'b010 || op_sel == 3'b111;

    assign req_ready = state_q == IDLE;
    assign busy      = state_q != IDLE;
    assign res_valid = state_q == DONE;
    assign alu_sel   = run ? op_q : 3'b000;
    assign alu_a     = run & a_q[0];
    assign alu_b     = run & b_q[0];
    assign alu_cin   = run & arith & carry_q;
    assign result    = res_q;
    assign res_cout  = cout_q;
    assign res_err   = err_q;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        err_d   = err_q;
        case (state_q)
            IDLE: if (req_valid) begin
                op_d    = op_sel;
                a_d     = op_a;
                b_d     = op_b;
                res_d   = '0;
                cnt_d   = '0;
                // subtract is a + ~b + 1, so the carry seeds with 1
                carry_d = op_sel == 3'b101;
                cout_d  = 1'b0;
                err_d   = illegal_in;
                state_d = illegal_in ? DONE : RUN;
            end
            RUN: begin
                res_d   = {alu_out, res_q[WIDTH-1:1]};
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                cnt_d   = cnt_q + 1'b1;
                carry_d = arith ? alu_cout : carry_q;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = DONE;
                    cout_d  = arith & alu_cout;
                end
            end
            DONE: if (res_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_alu_bit_sequencer.sv
// tb_alu_bit_sequencer: directed vector table plus hand-written handshake and
// mid-operation reset sequences, against a behavioural 1-bit slice.
module tb_alu_bit_sequencer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0, req_ready;
    logic [2:0] op_sel = 3'b000;
    logic [7:0] op_a = 8'h00, op_b = 8'h00;
    logic [2:0] alu_sel;
    logic       alu_a, alu_b, alu_cin, alu_out, alu_cout;
    logic       res_valid, res_ready = 1'b0;
    logic [7:0] result;
    logic       res_cout, res_err, busy;
    int         tests = 0, fails = 0;

    always #5 clk = ~clk;

    alu_bit_sequencer #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .op_sel(op_sel), .op_a(op_a), .op_b(op_b), .alu_sel(alu_sel),
        .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_out(alu_out),
        .alu_cout(alu_cout), .res_valid(res_valid), .res_ready(res_ready),
        .result(result), .res_cout(res_cout), .res_err(res_err), .busy(busy)
    );

    // behavioural slice; sub computes a + ~b + cin
    always_comb begin
        alu_out  = 1'b0;
        alu_cout = 1'b0;
        case (alu_sel)
            3'b000: alu_out = alu_a;
            3'b001: alu_out = ~alu_a;
            3'b011: alu_out = alu_a & alu_b;
            3'b100: alu_out = alu_a | alu_b;
            3'b101: begin
                alu_out  = alu_a ^ ~alu_b ^ alu_cin;
                alu_cout = (alu_a & ~alu_b) | (alu_cin & (alu_a ^ ~alu_b));
            end
            3'b110: begin
                alu_out  = alu_a ^ alu_b ^ alu_cin;
                alu_cout = (alu_a & alu_b) | (alu_cin & (alu_a ^ alu_b));
            end
            default: ;
        endcase
    end

    typedef struct packed {
        logic [2:0] op;
        logic [7:0] a, b, r;
        logic       c, e;
    } vec_t;
    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                         output logic [7:0] r, output logic c, output logic e,
                         output logic [2:0] sel, output int lat);
        @(negedge clk);
        req_valid = 1'b1;
        op_sel = op;
        op_a = a;
        op_b = b;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        sel = alu_sel;
        lat = 0;
        while (!res_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        r = result;
        c = res_cout;
        e = res_err;
        @(negedge clk);
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
    endtask

    logic [7:0] r;
    logic       c, e;
    logic [2:0] sel;
    int         lat;

    initial begin
        vecs[0] = '{3'b110, 8'h3C, 8'h0F, 8'h4B, 1'b0, 1'b0};
        vecs[1] = '{3'b101, 8'h07, 8'h05, 8'h02, 1'b1, 1'b0};
        vecs[2] = '{3'b101, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0};
        vecs[3] = '{3'b110, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0};
        vecs[4] = '{3'b000, 8'hA5, 8'h33, 8'hA5, 1'b0, 1'b0};
        vecs[5] = '{3'b001, 8'h5A, 8'h00, 8'hA5, 1'b0, 1'b0};
        vecs[6] = '{3'b011, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0};
        vecs[7] = '{3'b100, 8'h0F, 8'h30, 8'h3F, 1'b0, 1'b0};
        vecs[8] = '{3'b010, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b1};
        vecs[9] = '{3'b111, 8'h12, 8'h34, 8'h00, 1'b0, 1'b1};

        #1;
        check("rst_ctrl", {busy, res_valid, alu_sel, alu_a, alu_b, alu_cin, res_cout, res_err}, 0);
        check("rst_result", result, 8'h00);
        check("rst_req_ready", req_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, r, c, e, sel, lat);
            check($sformatf("v%0d_result", i), r, vecs[i].r);
            check($sformatf("v%0d_cout", i), c, vecs[i].c);
            check($sformatf("v%0d_err", i), e, vecs[i].e);
            check($sformatf("v%0d_latency", i), lat, vecs[i].e ? 0 : 8);
            check($sformatf("v%0d_alu_sel", i), sel, vecs[i].e ? 3'b000 : vecs[i].op);
            check($sformatf("v%0d_idle_after", i), {req_ready, res_valid}, 2'b10);
        end

        // result held in DONE while res_ready low and requests are ignored
        @(negedge clk);
        req_valid = 1'b1;
        op_sel = 3'b100;
        op_a = 8'h12;
        op_b = 8'h21;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat = 0;
        while (!res_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("hold_latency", lat, 8);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            req_valid = 1'b1;
            op_sel = 3'b011;
            op_a = 8'hFF;
            op_b = 8'hFF;
            @(posedge clk);
            #1;
            req_valid = 1'b0;
            check($sformatf("hold%0d_result", k), result, 8'h33);
            check($sformatf("hold%0d_flags", k), {req_ready, res_valid, busy}, 3'b011);
        end
        @(negedge clk);
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        check("release_flags", {req_ready, res_valid, busy}, 3'b100);
        check("release_result_held", result, 8'h33);
        do_op(3'b011, 8'hF0, 8'h3C, r, c, e, sel, lat);
        check("and_after_hold", r, 8'h30);
        check("and_after_hold_lat", lat, 8);

        // asynchronous reset three edges into RUN
        @(negedge clk);
        req_valid = 1'b1;
        op_sel = 3'b110;
        op_a = 8'h3C;
        op_b = 8'h0F;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("pre_rst_busy", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_ctrl", {busy, res_valid, alu_sel, alu_a, alu_b, alu_cin, res_cout, res_err}, 0);
        check("midrst_result", result, 8'h00);
        repeat (3) @(posedge clk);
        #1;
        check("midrst_no_valid", {res_valid, busy}, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;
        do_op(3'b001, 8'h5A, 8'h00, r, c, e, sel, lat);
        check("post_rst_not", r, 8'hA5);
        check("post_rst_cout", c, 0);
        check("post_rst_lat", lat, 8);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/alu_bit_sequencer.md
ALU_BIT_SEQUENCER -- requirements
Module: alu_bit_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand/result width in bits (bit-serial iterations per operation).
REQ-002 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port req_valid, input, 1, operation request present.
REQ-005 SHALL have port req_ready, output, 1, sequencer can accept a request.
REQ-006 SHALL have port op_sel, input, 3, opcode: 000 mov, 001 not, 011 and, 100 or, 101 sub, 110 add; 010 and 111 illegal.
REQ-007 SHALL have ports op_a and op_b, input, WIDTH each, operands.
REQ-008 SHALL have port alu_sel, output, 3, select driven to the 1-bit ALU slice.
REQ-009 SHALL have ports alu_a, alu_b, alu_cin, output, 1 each, current operand bits and carry-in to the slice.
REQ-010 SHALL have ports alu_out and alu_cout, input, 1 each, slice result bit and carry-out.
REQ-011 SHALL have port res_valid, output, 1, result available.
REQ-012 SHALL have port res_ready, input, 1, consumer accepts result.
REQ-013 SHALL have ports result (output, WIDTH), res_cout (output, 1), res_err (output, 1): assembled result, final carry, illegal-opcode flag.
REQ-014 SHALL have port busy, output, 1, high in any state other than IDLE.

Function
REQ-015 SHALL implement states IDLE, RUN, DONE.
REQ-016 IDLE: req_ready=1; on edge with req_valid=1, SHALL capture op_sel, op_a, op_b into internal registers and clear the bit counter.
REQ-017 On capture of a legal opcode SHALL go to RUN; on an illegal opcode SHALL go directly to DONE with result=0, res_cout=0, res_err=1.
REQ-018 RUN: alu_sel=captured opcode, alu_a=a_shift[0], alu_b=b_shift[0]; each edge SHALL shift alu_out into result at bit WIDTH-1, shift result and operand registers right by one, increment counter.
REQ-019 Carry register SHALL load 0 on capture for add, 1 for sub (slice computes a+~b+cin), 0 for all other ops; during RUN for add/sub it SHALL load alu_cout each edge; alu_cin=carry register for add/sub, 0 otherwise.
REQ-020 After the edge sampling bit WIDTH-1, SHALL go to DONE with res_cout=final carry register (0 for non-arithmetic ops), res_err=0.
REQ-021 Latency: capture on edge E0, bits sampled on E1..E_WIDTH, res_valid high from the cycle following E_WIDTH (WIDTH+1 edges total for legal ops, 1 edge for illegal).
REQ-022 DONE: res_valid=1, result/res_cout/res_err held stable; on edge with res_ready=1 SHALL return to IDLE; res_valid SHALL drop the following cycle.
REQ-023 req_ready SHALL be 0 in RUN and DONE; req_valid in those states SHALL be ignored and not queued.
REQ-024 Outside RUN, alu_sel SHALL be 000 and alu_a, alu_b, alu_cin SHALL be 0.
REQ-025 result, res_cout, res_err SHALL hold the last completed values in IDLE until the next capture clears them.
REQ-026 No back-to-back bypass: minimum one IDLE cycle between operations.

Reset
REQ-027 rst_n low SHALL immediately, independent of clk, force state IDLE, counter 0, carry 0, result 0, res_cout 0, res_err 0, res_valid 0, busy 0, alu_sel 000, alu_a/alu_b/alu_cin 0.
REQ-028 Reset mid-RUN or mid-DONE SHALL abandon the operation without producing res_valid; first capture possible on the first edge after rst_n rises.

Verification
REQ-029 Bench SHALL connect a behavioural 1-bit slice model matching the opcode map (illegal codes output 0) and WIDTH=8.
REQ-030 add 0x3C+0x0F accepted on E0 -> res_valid high after E8, result 0x4B, res_cout 0, res_err 0.
REQ-031 sub 0x07-0x05 -> 0x02, res_cout 1; sub 0x05-0x07 -> 0xFE, res_cout 0.
REQ-032 add 0xFF+0x01 -> result 0x00, res_cout 1 (wrap-around).
REQ-033 op_sel 111 -> res_valid one cycle after accept, result 0x00, res_err 1, alu_sel stays 000 throughout.
REQ-034 res_ready held low 5 cycles in DONE while req_valid pulses -> result stable, req_ready 0, no capture; after handshake IDLE next cycle, then and 0xF0&0x3C -> 0x30.
REQ-035 rst_n pulsed low after 3 RUN edges -> all outputs 0 immediately, no res_valid; next not 0x5A -> 0xA5, res_cout 0.
